// File: rtl/cnt_px_ln_addr_pkg.sv
// Shared types and constants for the OV7670 pixel/line counter and write-address generator.
package cam_pkg;

  localparam int QQVGA_H_PIX = 160;
  localparam int QQVGA_V_LIN = 120;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Debug view of the capture FSM and the sync edges that drive it.
  typedef struct packed {
    state_t state;
    logic   href_rise;
    logic   href_fall;
    logic   frame_start;
    logic   frame_end;
  } dbg_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cnt_px_ln_addr_if.sv
// Camera-side pixel strobe and frame-buffer write port of the capture counter.
interface cnt_px_ln_addr_if #(
  parameter int AW = 15
) ();
  // px_valid is a one-cycle strobe with no back-pressure (no ready): a pixel is
  // offered exactly once. wr_en is a one-cycle write strobe; addr is meaningful
  // only in a cycle where wr_en=1 and holds its last value otherwise.
  logic          vsync;
  logic          href;
  logic          px_valid;
  logic          wr_en;
  logic [AW-1:0] addr;

  modport master (output vsync, href, px_valid, input wr_en, addr);
  modport slave  (input vsync, href, px_valid, output wr_en, addr);
endinterface

// File: rtl/cnt_px_ln_addr_sync_edge_det.sv
// Registers a clk-synchronous level and flags entry into / exit from its POL level.
module sync_edge_det #(
  parameter logic POL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic enter,
  output logic leave
);

  logic d_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) d_q <= 1'b0;
    else          d_q <= d;
  end

  assign enter = (d == POL) && (d_q != POL);
  assign leave = (d != POL) && (d_q == POL);

endmodule

// File: rtl/cnt_px_ln_addr.sv
// Pixel/line counter and linear frame-buffer write-address generator for OV7670 capture.
module cnt_px_ln_addr
  import cam_pkg::*;
#(
  parameter int   H_PIX    = QQVGA_H_PIX,
  parameter int   V_LIN    = QQVGA_V_LIN,
  parameter int   AW       = 15,
  parameter logic VS_POL   = 1'b1,
  parameter logic ONE_SHOT = 1'b0,
  localparam int  PXW      = clog2(H_PIX + 1),
  localparam int  LNW      = clog2(V_LIN + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  cnt_px_ln_addr_if.slave  bus,
  output logic [PXW-1:0]   px_cnt,
  output logic [LNW-1:0]   ln_cnt,
  output logic             line_done,
  output logic             frame_done,
  output logic             ovf,
  output logic             busy,
  output dbg_t             dbg
);

  localparam logic [PXW-1:0] PX_MAX    = PXW'(H_PIX);
  localparam logic [LNW-1:0] LN_MAX    = LNW'(V_LIN);
  localparam logic [AW:0]    ROW_STEP  = (AW+1)'(H_PIX);
  localparam state_t         RST_STATE = ONE_SHOT ? IDLE : ARMED;

  state_t          state, next_state;
  logic            href_rise, href_fall, frame_start, frame_end;
  logic            in_active, accept, drop_ovf, close_line;
  logic            wr_en_q;
  logic [AW-1:0]   addr_q;
  // One extra bit so line_base can step past the last row without wrapping.
  logic [AW:0]     line_base, wr_ptr;

  sync_edge_det #(.POL(1'b1)) u_href (
    .clk, .reset_n, .d(bus.href), .enter(href_rise), .leave(href_fall)
  );

  sync_edge_det #(.POL(VS_POL)) u_vsync (
    .clk, .reset_n, .d(bus.vsync), .enter(frame_end), .leave(frame_start)
  );

  assign in_active  = (state == ACTIVE);
  assign accept     = in_active && bus.px_valid && bus.href &&
                      (px_cnt < PX_MAX) && (ln_cnt < LN_MAX);
  assign drop_ovf   = in_active && bus.px_valid &&
                      ((bus.href && (px_cnt == PX_MAX)) || (ln_cnt == LN_MAX));
  assign close_line = in_active && href_fall && (px_cnt != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RST_STATE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (ONE_SHOT && start) next_state = ARMED;
      ARMED:   if (frame_start) next_state = ACTIVE;
      ACTIVE:  if (frame_end) next_state = DONE;
      DONE:    next_state = ONE_SHOT ? IDLE : ARMED;
      default: next_state = RST_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      px_cnt     <= '0;
      ln_cnt     <= '0;
      line_base  <= '0;
      wr_ptr     <= '0;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      ovf        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      wr_en_q    <= 1'b0;
      line_done  <= 1'b0;
      frame_done <= (state == DONE);
      busy       <= (next_state == ARMED) || (next_state == ACTIVE);
      if ((state == ARMED) && frame_start) begin
        px_cnt    <= '0;
        ln_cnt    <= '0;
        line_base <= '0;
        wr_ptr    <= '0;
        addr_q    <= '0;
        ovf       <= 1'b0;
      end else if (in_active) begin
        if (accept) begin
          wr_en_q <= 1'b1;
          addr_q  <= wr_ptr[AW-1:0];
          wr_ptr  <= wr_ptr + (AW+1)'(1);
          px_cnt  <= px_cnt + PXW'(1);
        end
        if (drop_ovf) ovf <= 1'b1;
        // href is low here, so this never coincides with an accepted pixel.
        if (close_line) begin
          line_done <= 1'b1;
          if (ln_cnt < LN_MAX) ln_cnt <= ln_cnt + LNW'(1);
          line_base <= line_base + ROW_STEP;
          wr_ptr    <= line_base + ROW_STEP;
          px_cnt    <= '0;
        end
      end
    end
  end

  assign bus.wr_en = wr_en_q;
  assign bus.addr  = addr_q;

  always_comb begin
    dbg             = '0;
    dbg.state       = state;
    dbg.href_rise   = href_rise;
    dbg.href_fall   = href_fall;
    dbg.frame_start = frame_start;
    dbg.frame_end   = frame_end;
  end

endmodule

// File: tb/tb_cnt_px_ln_addr.sv
// Directed bench for cnt_px_ln_addr with a 4x3 geometry: continuous and single-shot instances.
module tb_cnt_px_ln_addr;
  import cam_pkg::*;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int AW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic vsync = 1'b1;
  logic href = 1'b0;
  logic px_valid = 1'b0;

  always #5 clk = ~clk;

  cnt_px_ln_addr_if #(.AW(AW)) bus0 ();
  cnt_px_ln_addr_if #(.AW(AW)) bus1 ();

  assign bus0.vsync = vsync;
  assign bus0.href = href;
  assign bus0.px_valid = px_valid;
  assign bus1.vsync = vsync;
  assign bus1.href = href;
  assign bus1.px_valid = px_valid;

  logic [2:0] px_cnt0, px_cnt1;
  logic [1:0] ln_cnt0, ln_cnt1;
  logic       line_done0, line_done1, frame_done0, frame_done1;
  logic       ovf0, ovf1, busy0, busy1;
  dbg_t       dbg0, dbg1;

  cnt_px_ln_addr #(.H_PIX(H), .V_LIN(V), .AW(AW), .VS_POL(1'b1), .ONE_SHOT(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start), .bus(bus0),
    .px_cnt(px_cnt0), .ln_cnt(ln_cnt0), .line_done(line_done0),
    .frame_done(frame_done0), .ovf(ovf0), .busy(busy0), .dbg(dbg0)
  );

  cnt_px_ln_addr #(.H_PIX(H), .V_LIN(V), .AW(AW), .VS_POL(1'b1), .ONE_SHOT(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .bus(bus1),
    .px_cnt(px_cnt1), .ln_cnt(ln_cnt1), .line_done(line_done1),
    .frame_done(frame_done1), .ovf(ovf1), .busy(busy1), .dbg(dbg1)
  );

  // ---------------- checking ----------------
  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [13:0] pack0();
    return {bus0.wr_en, bus0.addr, line_done0, frame_done0, ovf0, px_cnt0, ln_cnt0, busy0};
  endfunction

  function automatic logic [13:0] pack1();
    return {bus1.wr_en, bus1.addr, line_done1, frame_done1, ovf1, px_cnt1, ln_cnt1, busy1};
  endfunction

  // ---------------- scoreboard ----------------
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] exp1_q[$];
  logic [AW-1:0] e0, e1;
  int ld_n0 = 0;
  int fd_n0 = 0;
  int fd_n1 = 0;

  always @(negedge clk) begin
    if (bus0.wr_en) begin
      if (exp_q.size() == 0) check("wr0_unexpected", 32'(bus0.wr_en), 32'd0);
      else begin
        e0 = exp_q.pop_front();
        check("wr0_addr", 32'(bus0.addr), 32'(e0));
      end
    end
    if (bus1.wr_en) begin
      if (exp1_q.size() == 0) check("wr1_unexpected", 32'(bus1.wr_en), 32'd0);
      else begin
        e1 = exp1_q.pop_front();
        check("wr1_addr", 32'(bus1.addr), 32'(e1));
      end
    end
    if (line_done0) ld_n0++;
    if (frame_done0) fd_n0++;
    if (frame_done1) fd_n1++;
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic vs, input logic hr, input logic pv);
    vsync = vs;
    href = hr;
    px_valid = pv;
    @(posedge clk);
    #1;
  endtask

  task automatic frame_begin();
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic line(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic frame_end();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0);
  endtask

  task automatic full_frame();
    frame_begin();
    for (int l = 0; l < V; l++) line(H);
    frame_end();
  endtask

  task automatic push0(input int first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(AW'(first + i));
  endtask

  task automatic push1(input int first, input int n);
    for (int i = 0; i < n; i++) exp1_q.push_back(AW'(first + i));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          vs, hr, pv;
    logic          wr;
    logic [AW-1:0] addr;
    logic          ld, fd, ovf;
    logic [2:0]    px;
    logic [1:0]    ln;
    logic          busy;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(input logic vs, hr, pv, wr, input int addr,
                              input logic ld, fd, ovf, input int px, input int ln,
                              input logic busy);
    vec_t v;
    v.vs = vs; v.hr = hr; v.pv = pv; v.wr = wr; v.addr = AW'(addr);
    v.ld = ld; v.fd = fd; v.ovf = ovf; v.px = 3'(px); v.ln = 2'(ln); v.busy = busy;
    return v;
  endfunction

  int ld_base, fd_base;

  initial begin
    // Short line 0 (2 px, px_valid on its href fall), full line 1 plus one
    // overflow pixel, then href fall together with VSYNC rise.
    //            vs hr pv  wr addr ld fd ov px ln busy
    tbl[0]  = mk(0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 1);
    tbl[1]  = mk(0, 1, 1,  1, 0,  0, 0, 0, 1, 0, 1);
    tbl[2]  = mk(0, 1, 1,  1, 1,  0, 0, 0, 2, 0, 1);
    tbl[3]  = mk(0, 0, 1,  0, 1,  1, 0, 0, 0, 1, 1);
    tbl[4]  = mk(0, 0, 0,  0, 1,  0, 0, 0, 0, 1, 1);
    tbl[5]  = mk(0, 1, 1,  1, 4,  0, 0, 0, 1, 1, 1);
    tbl[6]  = mk(0, 1, 1,  1, 5,  0, 0, 0, 2, 1, 1);
    tbl[7]  = mk(0, 1, 1,  1, 6,  0, 0, 0, 3, 1, 1);
    tbl[8]  = mk(0, 1, 1,  1, 7,  0, 0, 0, 4, 1, 1);
    tbl[9]  = mk(0, 1, 1,  0, 7,  0, 0, 1, 4, 1, 1);
    tbl[10] = mk(1, 0, 0,  0, 7,  1, 0, 1, 0, 2, 0);
    tbl[11] = mk(1, 0, 0,  0, 7,  0, 1, 1, 0, 2, 1);
    tbl[12] = mk(1, 0, 0,  0, 7,  0, 0, 1, 0, 2, 1);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_outs0", 32'(pack0()), 32'd0);
    check("rst_outs1", 32'(pack1()), 32'd0);
    check("rst_state0", 32'(dbg0.state), 32'(ARMED));
    check("rst_state1", 32'(dbg1.state), 32'(IDLE));
    reset_n = 1'b1;
    repeat (2) cyc(1'b1, 1'b0, 1'b0);

    // Full frame: 3 lines of 4 pixels
    ld_base = ld_n0;
    fd_base = fd_n0;
    push0(0, 12);
    full_frame();
    check("full_q_empty", 32'(exp_q.size()), 32'd0);
    check("full_line_done", 32'(ld_n0 - ld_base), 32'd3);
    check("full_frame_done", 32'(fd_n0 - fd_base), 32'd1);
    check("full_ovf", 32'(ovf0), 32'd0);
    check("full_ln_cnt", 32'(ln_cnt0), 32'd3);

    // Cycle-by-cycle vector table
    exp_q.push_back(AW'(0));
    exp_q.push_back(AW'(1));
    push0(4, 4);
    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].vs, tbl[i].hr, tbl[i].pv);
      check($sformatf("vec[%0d]", i), 32'(pack0()),
            32'({tbl[i].wr, tbl[i].addr, tbl[i].ld, tbl[i].fd, tbl[i].ovf,
                 tbl[i].px, tbl[i].ln, tbl[i].busy}));
    end
    check("vec_q_empty", 32'(exp_q.size()), 32'd0);

    // Long line: 6 px in line 0, 4 px in line 1
    push0(0, 8);
    frame_begin();
    line(6);
    line(4);
    frame_end();
    check("long_q_empty", 32'(exp_q.size()), 32'd0);
    check("long_ovf", 32'(ovf0), 32'd1);
    check("long_ln_cnt", 32'(ln_cnt0), 32'd2);

    // Fourth line is beyond the geometry
    ld_base = ld_n0;
    push0(0, 12);
    frame_begin();
    for (int l = 0; l < V; l++) line(H);
    line(2);
    frame_end();
    check("l4_q_empty", 32'(exp_q.size()), 32'd0);
    check("l4_ovf", 32'(ovf0), 32'd1);
    check("l4_ln_cnt", 32'(ln_cnt0), 32'd3);
    check("l4_line_done", 32'(ld_n0 - ld_base), 32'd3);

    // Single-shot instance: idle until start, then exactly one frame
    check("os_idle_busy", 32'(busy1), 32'd0);
    check("os_idle_fd", 32'(fd_n1), 32'd0);
    start = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    start = 1'b0;
    check("os_armed_busy", 32'(busy1), 32'd1);
    check("os_armed_state", 32'(dbg1.state), 32'(ARMED));
    push0(0, 12);
    push1(0, 12);
    full_frame();
    check("os_q1_empty", 32'(exp1_q.size()), 32'd0);
    check("os_fd", 32'(fd_n1), 32'd1);
    check("os_done_busy", 32'(busy1), 32'd0);
    check("os_done_state", 32'(dbg1.state), 32'(IDLE));
    push0(0, 12);
    full_frame();
    check("os_second_fd", 32'(fd_n1), 32'd1);
    check("os_second_q0_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame at addr 5
    push0(0, 6);
    frame_begin();
    line(4);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    #1;
    check("mid_addr", 32'(bus0.addr), 32'd5);
    fd_base = fd_n0;
    reset_n = 1'b0;
    vsync = 1'b1;
    href = 1'b0;
    px_valid = 1'b0;
    #1;
    check("mid_rst_outs0", 32'(pack0()), 32'd0);
    check("mid_q_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) cyc(1'b1, 1'b0, 1'b0);
    check("mid_no_fd", 32'(fd_n0 - fd_base), 32'd0);
    push0(0, 4);
    frame_begin();
    line(4);
    frame_end();
    check("restart_q_empty", 32'(exp_q.size()), 32'd0);
    check("restart_fd", 32'(fd_n0 - fd_base), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
